// File: rtl/pmc_matrix_shift_sequencer_if.sv
// Command/status bundle between the PMC register block (master) and the
// matrix shift sequencer (slave), including the matrix-side serial lines.
interface pmc_matrix_shift_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int DIV_W  = 8
);
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] din_a;
    logic [DATA_W-1:0] din_b;
    logic [5:0]        bit_cnt;
    logic [DIV_W-1:0]  half_period;
    logic [DIV_W-1:0]  strobe_len;
    logic              busy;
    logic              done;
    logic              clk_sh;
    logic              sh_a;
    logic              sh_b;
    logic              strobe;

    modport master (
        output start, abort, din_a, din_b, bit_cnt, half_period, strobe_len,
        input  busy, done, clk_sh, sh_a, sh_b, strobe
    );

    modport slave (
        input  start, abort, din_a, din_b, bit_cnt, half_period, strobe_len,
        output busy, done, clk_sh, sh_a, sh_b, strobe
    );
endinterface

// File: rtl/pmc_matrix_shift_sequencer.sv
// Shifts up to DATA_W bits onto sh_a/sh_b with programmable clk_sh timing, then strobes.
// Define PMC_SEQ_MSB_FIRST_EN to shift MSB-first instead of the default LSB-first.
module pmc_matrix_shift_sequencer #(
    parameter int DATA_W = 32,
    parameter int DIV_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pmc_matrix_shift_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOW    = 2'd1,
        HIGH   = 2'd2,
        STROBE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  h_q, h_d;
    logic [DIV_W-1:0]  s_q, s_d;
    logic [5:0]        bits_q, bits_d;
    logic [DATA_W-1:0] sra_q, sra_d;
    logic [DATA_W-1:0] srb_q, srb_d;
    logic              done_q, done_d;

    logic [DIV_W-1:0]  h_eff, s_eff;
    logic [5:0]        bit_eff;
    logic [DATA_W-1:0] load_a, load_b;
    logic [DATA_W-1:0] shift_a, shift_b;
    logic              cur_a, cur_b;

    assign h_eff   = (bus.half_period == '0) ? DIV_W'(1) : bus.half_period;
    assign s_eff   = (bus.strobe_len == '0) ? DIV_W'(1) : bus.strobe_len;
    assign bit_eff = (bus.bit_cnt > 6'(DATA_W)) ? 6'(DATA_W) : bus.bit_cnt;

`ifdef PMC_SEQ_MSB_FIRST_EN
    // Pre-align so bit (bit_cnt-1) sits at the MSB; the register then shifts left.
    assign load_a  = bus.din_a << (6'(DATA_W) - bit_eff);
    assign load_b  = bus.din_b << (6'(DATA_W) - bit_eff);
    assign cur_a   = sra_q[DATA_W-1];
    assign cur_b   = srb_q[DATA_W-1];
    assign shift_a = {sra_q[DATA_W-2:0], 1'b0};
    assign shift_b = {srb_q[DATA_W-2:0], 1'b0};
`else
    assign load_a  = bus.din_a;
    assign load_b  = bus.din_b;
    assign cur_a   = sra_q[0];
    assign cur_b   = srb_q[0];
    assign shift_a = {1'b0, sra_q[DATA_W-1:1]};
    assign shift_b = {1'b0, srb_q[DATA_W-1:1]};
`endif

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        s_d     = s_q;
        bits_d  = bits_q;
        sra_d   = sra_q;
        srb_d   = srb_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    h_d    = h_eff;
                    s_d    = s_eff;
                    bits_d = bit_eff;
                    sra_d  = load_a;
                    srb_d  = load_b;
                    if (bit_eff != '0) begin
                        state_d = LOW;
                        cnt_d   = h_eff - DIV_W'(1);
                    end else begin
                        state_d = STROBE;
                        cnt_d   = s_eff - DIV_W'(1);
                    end
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = h_q - DIV_W'(1);
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    sra_d  = shift_a;
                    srb_d  = shift_b;
                    bits_d = bits_q - 6'd1;
                    if (bits_q == 6'd1) begin
                        state_d = STROBE;
                        cnt_d   = s_q - DIV_W'(1);
                    end else begin
                        state_d = LOW;
                        cnt_d   = h_q - DIV_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Cancel beats any in-flight transition and suppresses the done pulse.
        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
            bits_d  = '0;
            sra_d   = '0;
            srb_d   = '0;
            done_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            s_q     <= '0;
            bits_q  <= '0;
            sra_q   <= '0;
            srb_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            s_q     <= s_d;
            bits_q  <= bits_d;
            sra_q   <= sra_d;
            srb_q   <= srb_d;
            done_q  <= done_d;
        end
    end

    // Outputs decode straight from registers, so async reset clears them immediately.
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.clk_sh = (state_q == HIGH);
    assign bus.strobe = (state_q == STROBE);
    assign bus.sh_a   = ((state_q == LOW) || (state_q == HIGH)) ? cur_a : 1'b0;
    assign bus.sh_b   = ((state_q == LOW) || (state_q == HIGH)) ? cur_b : 1'b0;

endmodule

// File: tb/tb_pmc_matrix_shift_sequencer.sv
// Directed self-checking bench for pmc_matrix_shift_sequencer; expectations follow
// PMC_SEQ_MSB_FIRST_EN when it is defined for the build.
module tb_pmc_matrix_shift_sequencer;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    pmc_matrix_shift_sequencer_if #(.DATA_W(32), .DIV_W(8)) bus ();

    pmc_matrix_shift_sequencer #(.DATA_W(32), .DIV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {26'd0, bus.busy, bus.done, bus.clk_sh, bus.sh_a, bus.sh_b, bus.strobe};
    endfunction

    // Order in which data bits should appear on the line, first bit in bit 0.
    function automatic logic [31:0] exp_bits(input logic [31:0] word, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
`ifdef PMC_SEQ_MSB_FIRST_EN
            r[i] = word[n-1-i];
`else
            r[i] = word[i];
`endif
        end
        return r;
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input int n, input int h, input int s);
        bus.din_a       = a;
        bus.din_b       = b;
        bus.bit_cnt     = 6'(n);
        bus.half_period = 8'(h);
        bus.strobe_len  = 8'(s);
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    // Watches one sequence from its first busy cycle; returns in the done cycle.
    task automatic observe(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int n, input int h, input int s);
        int n_eff, h_eff, s_eff;
        int busy_c, pulses, hi_c, str_c, cyc;
        logic prev_clk, last_a, last_b, bad;
        logic [31:0] cap_a, cap_b;
        n_eff = (n > 32) ? 32 : n;
        h_eff = (h == 0) ? 1 : h;
        s_eff = (s == 0) ? 1 : s;
        busy_c = 0; pulses = 0; hi_c = 0; str_c = 0; cyc = 0;
        prev_clk = 1'b0; last_a = 1'b0; last_b = 1'b0; bad = 1'b0;
        cap_a = '0; cap_b = '0;
        while (bus.busy && cyc < 2000) begin
            busy_c++;
            if (bus.clk_sh && !prev_clk) begin
                if (pulses < 32) begin
                    cap_a[pulses] = bus.sh_a;
                    cap_b[pulses] = bus.sh_b;
                end
                pulses++;
                last_a = bus.sh_a;
                last_b = bus.sh_b;
            end
            if (bus.clk_sh && prev_clk && ((bus.sh_a != last_a) || (bus.sh_b != last_b))) bad = 1'b1;
            if (bus.strobe && (bus.sh_a || bus.sh_b || bus.clk_sh)) bad = 1'b1;
            if (bus.done) bad = 1'b1;
            hi_c  += int'(bus.clk_sh);
            str_c += int'(bus.strobe);
            prev_clk = bus.clk_sh;
            cyc++;
            tick();
        end
        check({tag, "_timeout"}, 32'(cyc >= 2000), 32'd0);
        check({tag, "_busy_cycles"}, busy_c, 2 * h_eff * n_eff + s_eff);
        check({tag, "_pulses"}, pulses, n_eff);
        check({tag, "_clk_hi_cycles"}, hi_c, h_eff * n_eff);
        check({tag, "_strobe_cycles"}, str_c, s_eff);
        check({tag, "_sh_a_bits"}, cap_a, exp_bits(a, n_eff));
        check({tag, "_sh_b_bits"}, cap_b, exp_bits(b, n_eff));
        check({tag, "_line_rules"}, 32'(bad), 32'd0);
        check({tag, "_done"}, outs(), 32'b010000);
    endtask

    initial begin
        logic [31:0] cap;
        int   pulses;
        logic prev_clk, seen;

        // Reset held with arbitrary inputs
        rst_n           = 1'b0;
        bus.start       = 1'b1;
        bus.abort       = 1'b0;
        bus.din_a       = $urandom;
        bus.din_b       = $urandom;
        bus.bit_cnt     = 6'($urandom);
        bus.half_period = 8'($urandom);
        bus.strobe_len  = 8'($urandom);
        repeat (3) tick();
        check("reset_outs", outs(), 32'd0);
        bus.start = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_outs", outs(), 32'd0);

        // Main shift pattern, then a single-bit pattern
        launch(32'hA, 32'h5, 4, 2, 3);
        observe("lsb4", 32'hA, 32'h5, 4, 2, 3);
        tick();
        check("done_one_cycle", outs(), 32'd0);

        launch(32'h1, 32'h0, 4, 1, 1);
        observe("one_hot", 32'h1, 32'h0, 4, 1, 1);
        tick();

        // Zero half-period / strobe length, and zero bit count
        launch(32'hFFFF_FFFF, 32'h0, 1, 0, 0);
        observe("zero_fields", 32'hFFFF_FFFF, 32'h0, 1, 0, 0);
        tick();
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3, 2);
        observe("zero_bits", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3, 2);
        tick();

        // Bit count clamp; next start lands in the done cycle
        launch(32'hFFFF_FFFF, 32'h1234_5678, 40, 1, 1);
        observe("clamp", 32'hFFFF_FFFF, 32'h1234_5678, 40, 1, 1);
        launch(32'h3, 32'hC, 2, 1, 2);
        observe("back_to_back", 32'h3, 32'hC, 2, 1, 2);
        tick();

        // Start while busy is dropped; abort during the third HIGH
        launch(32'hA, 32'h5, 4, 2, 3);
        cap = '0; pulses = 0; prev_clk = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (bus.clk_sh && !prev_clk) begin
                cap[pulses] = bus.sh_a;
                pulses++;
            end
            prev_clk = bus.clk_sh;
            if (c == 11) begin
                check("abort_in_high", 32'(bus.clk_sh), 32'd1);
                check("abort_pulses", pulses, 3);
            end
            if (c == 6) begin
                bus.din_a   = 32'h5;
                bus.din_b   = 32'hA;
                bus.bit_cnt = 6'd8;
            end
            bus.start = (c == 6);
            bus.abort = (c == 11);
            tick();
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_outs", outs(), 32'd0);
        check("abort_bits_kept", cap, exp_bits(32'hA, 4) & 32'h7);
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | bus.done | bus.busy;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        launch(32'h6, 32'h9, 3, 1, 2);
        observe("post_abort", 32'h6, 32'h9, 3, 1, 2);
        tick();

        // abort and start together in IDLE: abort wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_beats_start", outs(), 32'd0);

        // Asynchronous reset in the middle of STROBE
        launch(32'h0, 32'h0, 0, 1, 6);
        tick();
        tick();
        check("strobe_active", outs(), 32'b100001);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outs", outs(), 32'd0);
        tick();
        check("reset_no_done", outs(), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("after_reset_idle", outs(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
